// File: rtl/output_port_fifo_pkg.sv
// Shared sizing constants for the CPU output-port FIFO.
package output_port_fifo_pkg;

    localparam int OPF_DATA_W = 8;
    localparam int OPF_DEPTH  = 16;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous (fall-through) read.
// Write lands on the rising edge; read data follows rd_addr combinationally.
module fifo_mem
    import output_port_fifo_pkg::*;
#(
    parameter int WIDTH = OPF_DATA_W,
    parameter int DEPTH = OPF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_dat;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/output_port_fifo.sv
// Output-port byte FIFO: captures data_in on each go strobe, drains over valid/ready.
// Head byte visible the cycle after it is written; writes while full are dropped and flagged.
module output_port_fifo
    import output_port_fifo_pkg::*;
#(
    parameter  int WIDTH = OPF_DATA_W,
    parameter  int DEPTH = OPF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clear_ovf
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          rd_fire;
    logic          wr_en;

    assign empty     = (level_q == '0);
    assign full      = (level_q == (AW+1)'(DEPTH));
    assign out_valid = !empty;
    assign level     = level_q;
    assign overflow  = overflow_q;

    // A full queue can still take a byte when the head leaves in the same cycle.
    assign rd_fire = out_valid && out_ready;
    assign wr_en   = go && (!full || rd_fire);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_fire) begin
            level_d = level_q + (AW+1)'(1);
        end else if (rd_fire && !wr_en) begin
            level_d = level_q - (AW+1)'(1);
        end
        // A drop in the same cycle as clear_ovf keeps the flag set.
        if (go && !wr_en) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (data_in),
        .rd_addr (rd_ptr_q),
        .rd_dat  (out_data)
    );

endmodule

// File: doc/output_port_fifo.md
Name: output_port_fifo

Overview:
Buffers bytes the CPU writes to its output port, so a slower consumer (UART, display, bench monitor) can drain them without stalling the CPU. Sits directly downstream of the computer's output port.
- Write side: captures the port data bus on each output strobe (the c_go pulse), one byte per strobe.
- Read side: presents bytes in order on a valid/ready interface.
- Status: occupancy, full/empty, and a sticky overflow flag.

Parameters:
WIDTH, 8, data width in bits; matches the CPU output port.
DEPTH, 16, number of entries; power of two and at least 2.
AW, $clog2(DEPTH), pointer width; derived, must not be overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
go  input  1  write strobe from the CPU output-port control (c_go); one byte per cycle it is high.
data_in  input  WIDTH  output-port data, sampled when go=1.
out_data  output  WIDTH  head-of-queue byte; meaningful only while out_valid=1.
out_valid  output  1  queue non-empty; the head byte is presented.
out_ready  input  1  consumer accepts the head byte when out_valid&&out_ready.
level  output  AW+1  number of stored entries, 0..DEPTH.
full  output  1  level==DEPTH.
empty  output  1  level==0.
overflow  output  1  sticky; a write was dropped because the queue was full.
clear_ovf  input  1  clears overflow on the next edge.

Behaviour:
- Reset (reset=1 at a rising edge): wr_ptr=0, rd_ptr=0, level=0, overflow=0. Consequently out_valid=0, empty=1, full=0. Memory contents are not cleared. Reset overrides every other input, including when asserted mid-stream.
- Storage: DEPTH x WIDTH register array; read and write pointers are AW bits wide and wrap modulo DEPTH.
- Output path: out_data is the combinational read of mem[rd_ptr] (first-word fall-through).
- Flag derivation: out_valid = !empty; full and empty are decoded from level.
- Write acceptance: wr_en = go && (!full || rd_fire), where rd_fire = out_valid && out_ready.
  - When wr_en=1, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read acceptance: when rd_fire=1, rd_ptr increments.
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both occur in the same cycle, or when neither occurs.
- Latency: a byte written into an empty queue at edge N drives out_valid=1 and out_data=byte immediately after edge N, i.e. one cycle after the strobe cycle.
- Boundary cases:
  - Full, go=1, out_ready=0: byte dropped; pointers and level unchanged; overflow <= 1.
  - Full, go=1, out_ready=1: read and write both accepted; level stays DEPTH; no overflow.
  - Empty, go=1, out_ready=1: write accepted; no read occurs (out_valid was 0); level becomes 1.
  - Empty, out_ready=1, go=0: no state change.
  - Pointer wrap: going from DEPTH-1 to 0 must preserve FIFO ordering.
  - clear_ovf=1 in the same cycle as a new drop: overflow stays 1 (set wins).
- No internal state machine beyond the counters.
- Consumers must not assume out_data holds the dequeued byte after the accept edge.

Decomposition:
- No new package is needed. If the team's shared CPU package exists, WIDTH defaults to its data-bus width constant.
- One natural sub-module: fifo_mem, a DEPTH x WIDTH synchronous-write, asynchronous-read register file indexed by the pointers.
- Pointer, level and flag logic stay in output_port_fifo.

Test Plan:
1. Reset, then go pulses with data_in=0x11,0x22,0x33 and out_ready=0 -> level=3, out_valid=1, out_data=0x11, empty=0.
2. Hold out_ready=1 after scenario 1 -> out_data reads 0x11,0x22,0x33 on consecutive cycles, then out_valid=0, level=0, empty=1.
3. Write 16 bytes 0x00..0x0F with out_ready=0, then go with 0xAA -> full=1, level=16, overflow=1; draining yields 0x00..0x0F (0xAA absent). Pulse clear_ovf -> overflow=0.
4. Full queue, go=1 with data_in=0x55 and out_ready=1 in the same cycle -> level stays 16, overflow=0; 0x55 is emerged last after draining.
5. Fill 10 bytes, drain 10, write 0xC0..0xC7 -> pointers cross the wrap boundary; bytes emerge in order 0xC0..0xC7.
6. Assert reset with level=5 mid-stream -> next cycle level=0, out_valid=0, overflow=0; a subsequent write of 0x7E is read back first.
